fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction register in the multicycle RV32I datapath.
- Owns the program counter and runs the read handshake with instruction memory.
- Captures the returned word and drives it into the instruction register with a one-cycle load pulse.
- Supports PC redirects (branch/jump targets) from the control unit, a misalignment check, and a bounded-wait memory timeout.

Parameters:
- RESET_PC, 32'h0000_0060, PC value after reset.
- TIMEOUT_CYCLES, 64, max cycles mem_read may stay high without mem_resp before the fetch is aborted; legal range 1..255.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  control unit requests the next instruction; sampled only in IDLE.
- pc_load  in  1  redirect strobe.
- pc_target  in  32  redirect address, valid with pc_load.
- mem_rdata  in  32  instruction word from memory, valid with mem_resp.
- mem_resp  in  1  memory completion, single-cycle pulse.
- mem_read  out  1  memory read request, held until mem_resp or timeout.
- mem_address  out  32  fetch address; equals pc_out, stable while mem_read=1.
- ir_load  out  1  one-cycle load strobe to the instruction register.
- ir_data  out  32  captured instruction word.
- fetch_done  out  1  one-cycle pulse, coincident with ir_load.
- pc_out  out  32  current PC.
- misaligned_fault  out  1  sticky; set when a redirect target has bits [1:0] != 0.
- timeout_fault  out  1  one-cycle pulse when a fetch is aborted.

Behaviour:
- Reset (async, rst_n=0):
  - pc_out=RESET_PC.
  - mem_read=0, ir_load=0, fetch_done=0, timeout_fault=0, misaligned_fault=0.
  - ir_data=0, wait counter=0, redirect-pending=0.
  - state=IDLE.
  - Reset mid-fetch abandons the fetch; a late mem_resp after reset is ignored in IDLE.
- All outputs are registered except mem_address, which is a wire from pc_out.
- States: IDLE, REQ, DONE.
- IDLE:
  - fetch_req=1 and misaligned_fault=0 -> REQ. mem_read=1 from the next cycle; counter cleared.
  - fetch_req while misaligned_fault=1 is ignored.
- REQ:
  - mem_read held at 1 and the counter increments each cycle.
  - mem_resp=1 -> latch mem_rdata into ir_data, go to DONE, mem_read=0 next cycle.
  - Counter reaches TIMEOUT_CYCLES with no mem_resp -> mem_read=0, one-cycle timeout_fault pulse, go to IDLE. PC is unchanged and ir_data keeps its old value.
  - If mem_resp arrives in the same cycle the counter hits the limit, mem_resp wins.
- DONE (exactly one cycle):
  - ir_load=1 and fetch_done=1.
  - At the end of the cycle, pc_out <= pending target if a redirect is pending, else pc_out+4. Wrap-around is modulo 2^32, so 32'hFFFF_FFFC+4 = 0.
  - Return to IDLE.
- Latency: fetch_req in cycle 0 -> mem_read in cycle 1. mem_resp in cycle N -> ir_load in cycle N+1. Minimum fetch is 3 cycles (req -> resp -> load).
- Redirect rules:
  - pc_load in IDLE: pc_out <= pc_target next cycle.
  - pc_load in REQ or DONE: target stored as pending and applied at the DONE PC update. This keeps mem_address stable during the handshake.
  - A later pc_load overwrites an earlier pending target.
  - pc_load in the same IDLE cycle as fetch_req: the redirect applies first and the fetch uses the new PC.
  - pc_target[1:0] != 0: PC is not updated, misaligned_fault is set, and any pending redirect is cleared.
  - misaligned_fault clears only on reset or a subsequent aligned pc_load.
- mem_resp outside REQ is ignored.

Decomposition:
- The shared rv32i_types package gains:
  - fetch_state_t enum {IDLE, REQ, DONE}.
  - Constant RV32I_RESET_PC = 32'h60, used as the default for RESET_PC.
  - Constant INSTR_BYTES = 4.
- One natural sub-module, fetch_pc_reg: holds the PC with load/increment/redirect-pending logic and async reset.
- The FSM and timeout counter stay in the top module.

Test Plan:
- Reset release, then fetch_req=1 with mem_resp after 2 cycles returning 32'h0000_0013 -> mem_address=32'h60 while mem_read=1; ir_load pulses for one cycle with ir_data=32'h13; pc_out=32'h64 afterwards.
- During REQ, pc_load with pc_target=32'h200 -> mem_address stays 32'h60 until mem_resp; after DONE, pc_out=32'h200 (not 32'h64).
- pc_load with pc_target=32'h202 in IDLE -> misaligned_fault=1 and pc_out unchanged; subsequent fetch_req produces no mem_read; pc_load with 32'h300 clears the fault.
- TIMEOUT_CYCLES=4, never assert mem_resp -> mem_read high for exactly 4 cycles, then a one-cycle timeout_fault pulse; pc_out and ir_data are unchanged.
- pc_out=32'hFFFF_FFFC with a completed fetch -> pc_out=32'h0000_0000.
- Drive rst_n low in REQ, then a stray mem_resp after release -> no ir_load; pc_out=32'h60 and mem_read=0.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I type and constant definitions.
// Used by the fetch stage and its PC register.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } fetch_state_t;

    localparam logic [31:0] RV32I_RESET_PC = 32'h0000_0060;
    localparam logic [31:0] INSTR_BYTES    = 32'd4;

    function automatic logic addr_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with immediate, deferred and sequential update paths.
// Redirects arriving mid-fetch are parked until the fetch completes.
module fetch_pc_reg
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = RV32I_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_load,
    input  logic [31:0] pc_target,
    input  logic        in_idle,
    input  logic        advance,
    output logic [31:0] pc_out
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pend_q;
    logic [31:0] pend_d;
    logic        pend_vld_q;
    logic        pend_vld_d;
    logic        ld_ok;

    assign ld_ok  = pc_load && addr_aligned(pc_target);
    assign pc_out = pc_q;

    always_comb begin
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (pc_load && !ld_ok) begin
            pend_vld_d = 1'b0;
        end else if (ld_ok && in_idle) begin
            pc_d = pc_target;
        end else if (ld_ok) begin
            pend_d     = pc_target;
            pend_vld_d = 1'b1;
        end
        // Completion consumes whichever target is newest, including one this cycle
        if (advance) begin
            pc_d       = pend_vld_d ? pend_d : pc_q + INSTR_BYTES;
            pend_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: memory read handshake, timeout, IR load pulse.
// The PC and redirect bookkeeping live in fetch_pc_reg.
module fetch_unit
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC       = RV32I_RESET_PC,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_req,
    input  logic        pc_load,
    input  logic [31:0] pc_target,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic        mem_read,
    output logic [31:0] mem_address,
    output logic        ir_load,
    output logic [31:0] ir_data,
    output logic        fetch_done,
    output logic [31:0] pc_out,
    output logic        misaligned_fault,
    output logic        timeout_fault
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    fetch_state_t state;
    fetch_state_t state_n;
    logic [7:0]   wait_cnt;
    logic         start;
    logic         to_hit;

    fetch_pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .pc_load  (pc_load),
        .pc_target(pc_target),
        .in_idle  (state == IDLE),
        .advance  (state == DONE),
        .pc_out   (pc_out)
    );

    assign mem_address = pc_out;

    // A misaligned redirect in the request cycle also blocks the fetch
    assign start = fetch_req && !misaligned_fault
                && !(pc_load && !addr_aligned(pc_target));

    always_comb begin
        state_n = state;
        to_hit  = 1'b0;
        unique case (state)
            IDLE: if (start) state_n = REQ;
            REQ: begin
                if (mem_resp) begin
                    state_n = DONE;
                end else if (wait_cnt == CNT_LAST) begin
                    state_n = IDLE;
                    to_hit  = 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            wait_cnt         <= '0;
            mem_read         <= 1'b0;
            ir_load          <= 1'b0;
            fetch_done       <= 1'b0;
            timeout_fault    <= 1'b0;
            misaligned_fault <= 1'b0;
            ir_data          <= '0;
        end else begin
            state         <= state_n;
            wait_cnt      <= (state == REQ) ? wait_cnt + 8'd1 : 8'd0;
            mem_read      <= (state_n == REQ);
            ir_load       <= (state_n == DONE);
            fetch_done    <= (state_n == DONE);
            timeout_fault <= to_hit;
            if (state == REQ && mem_resp) ir_data <= mem_rdata;
            if (pc_load) misaligned_fault <= !addr_aligned(pc_target);
        end
    end

endmodule
